// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter for two requesters sharing one mux path.
//
// Ports:
//   clk             rising-edge clock
//   n_reset         asynchronous active-low reset
//   req_a, req_b    requests for the shared path
//   data_a, data_b  requester data (mux inputs a and b)
//   gnt_a, gnt_b    grants, decoded from the state register (zero or one-hot)
//   sel             mux select, 1 = b; decoded from the state register
//   y               shared mux output, zero while idle
//   valid           y carries granted data (gnt_a | gnt_b)
//
// Optional feature: define MUX2_ARBITER_PREEMPT_EN to bound a grant to
// MAX_HOLD cycles while the other requester is waiting.

module mux2_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux2_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t state, state_nxt;

    // 1 when B was granted most recently; B after reset so A wins the first tie.
    logic last_gnt_b;
    logic hold_hit;

`ifdef MUX2_ARBITER_PREEMPT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;

    // Cleared on every grant entry (including a preemptive transfer),
    // counts held cycles and saturates so a late request still preempts.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_cnt <= '0;
        end else if (state_nxt == IDLE || state_nxt != state) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign hold_hit = (hold_cnt == HOLD_LAST);
`else
    assign hold_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            last_gnt_b <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == GRANT_A && state != GRANT_A)
                last_gnt_b <= 1'b0;
            else if (state_nxt == GRANT_B && state != GRANT_B)
                last_gnt_b <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b)
                    state_nxt = last_gnt_b ? GRANT_A : GRANT_B;
                else if (req_a)
                    state_nxt = GRANT_A;
                else if (req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_A: begin
                // Hand over directly when the owner leaves or its hold expires.
                if (!req_a)
                    state_nxt = req_b ? GRANT_B : IDLE;
                else if (hold_hit && req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_B: begin
                if (!req_b)
                    state_nxt = req_a ? GRANT_A : IDLE;
                else if (hold_hit && req_a)
                    state_nxt = GRANT_A;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_a = (state == GRANT_A);
    assign gnt_b = (state == GRANT_B);
    assign sel   = gnt_b;
    assign valid = gnt_a | gnt_b;

    always_comb begin
        y = '0;
        if (gnt_a)
            y = data_a;
        else if (gnt_b)
            y = data_b;
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             n_reset;
    logic             req_a, req_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic             gnt_a, gnt_b, sel, valid;
    logic [WIDTH-1:0] y;

    int tests = 0;
    int fails = 0;

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .req_a  (req_a),
        .req_b  (req_b),
        .data_a (data_a),
        .data_b (data_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .sel    (sel),
        .y      (y),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        n_reset = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        req_a   = 1'b1;
        req_b   = 1'b1;
        data_a  = 8'hFF;
        data_b  = 8'hEE;
        step();
        tests++; if (gnt_a !== 1'b0) begin fails++; $display("FAIL reset_gnt_a: got %b want 0", gnt_a); end
        tests++; if (gnt_b !== 1'b0) begin fails++; $display("FAIL reset_gnt_b: got %b want 0", gnt_b); end
        tests++; if (sel !== 1'b0)   begin fails++; $display("FAIL reset_sel: got %b want 0", sel); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests++; if (y !== 8'h00)    begin fails++; $display("FAIL reset_y: got %h want 00", y); end
        do_reset();
    endtask

    task automatic test_single_a();
        do_reset();
        @(negedge clk);
        req_a  = 1'b1;
        data_a = 8'hA5;
        #1;
        tests++; if (gnt_a !== 1'b0) begin fails++; $display("FAIL single_pre_edge_gnt_a: got %b want 0", gnt_a); end
        step();
        tests++; if (gnt_a !== 1'b1) begin fails++; $display("FAIL single_gnt_a: got %b want 1", gnt_a); end
        tests++; if (sel !== 1'b0)   begin fails++; $display("FAIL single_sel: got %b want 0", sel); end
        tests++; if (y !== 8'hA5)    begin fails++; $display("FAIL single_y: got %h want a5", y); end
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", valid); end
        @(negedge clk);
        req_a = 1'b0;
        step();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b want 0", valid); end
        tests++; if (y !== 8'h00)    begin fails++; $display("FAIL idle_y: got %h want 00", y); end
        tests++; if (gnt_a !== 1'b0) begin fails++; $display("FAIL idle_gnt_a: got %b want 0", gnt_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 8'h11;
        data_b = 8'h3C;
        step();
        tests++; if ({gnt_a, gnt_b} !== 2'b10) begin fails++; $display("FAIL tie_first: got %b want 10", {gnt_a, gnt_b}); end
        @(negedge clk);
        req_a = 1'b0;
        step();
        tests++; if ({gnt_a, gnt_b} !== 2'b01) begin fails++; $display("FAIL handoff_gnt: got %b want 01", {gnt_a, gnt_b}); end
        tests++; if (sel !== 1'b1)   begin fails++; $display("FAIL handoff_sel: got %b want 1", sel); end
        tests++; if (y !== 8'h3C)    begin fails++; $display("FAIL handoff_y: got %h want 3c", y); end
        @(negedge clk);
        req_b = 1'b0;
        step();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL b_release_valid: got %b want 0", valid); end
        @(negedge clk);
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        tests++; if ({gnt_a, gnt_b} !== 2'b10) begin fails++; $display("FAIL rr_after_b: got %b want 10", {gnt_a, gnt_b}); end
        tests++; if (y !== 8'h11)    begin fails++; $display("FAIL rr_after_b_y: got %h want 11", y); end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        @(negedge clk);
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        tests++; if ({gnt_a, gnt_b} !== 2'b01) begin fails++; $display("FAIL rr_after_a: got %b want 01", {gnt_a, gnt_b}); end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic test_hold();
        int a_cycles;
        int bad;
        do_reset();
        @(negedge clk);
        req_a = 1'b1;
        req_b = 1'b1;
`ifdef MUX2_ARBITER_PREEMPT_EN
        a_cycles = 0;
        bad      = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (gnt_a && gnt_b) bad++;
            if (gnt_b) break;
            if (gnt_a) a_cycles++;
        end
        tests++; if (gnt_b !== 1'b1) begin fails++; $display("FAIL preempt_gnt_b: got %b want 1 (timeout)", gnt_b); end
        tests++; if (a_cycles != 4)  begin fails++; $display("FAIL preempt_len: got %0d want 4", a_cycles); end
        tests++; if (bad != 0)       begin fails++; $display("FAIL preempt_onehot: got %0d overlaps want 0", bad); end
`else
        a_cycles = 0;
        bad      = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (gnt_a === 1'b1 && gnt_b === 1'b0) a_cycles++;
            else bad++;
        end
        tests++; if (a_cycles != 100) begin fails++; $display("FAIL hold_len: got %0d want 100", a_cycles); end
        tests++; if (bad != 0)        begin fails++; $display("FAIL hold_other: got %0d bad cycles want 0", bad); end
`endif
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        req_a  = 1'b1;
        data_a = 8'h5A;
        step();
        tests++; if (gnt_a !== 1'b1) begin fails++; $display("FAIL arst_setup_gnt_a: got %b want 1", gnt_a); end
        #2;
        n_reset = 1'b0;
        #1;
        tests++; if (gnt_a !== 1'b0) begin fails++; $display("FAIL arst_gnt_a: got %b want 0", gnt_a); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b want 0", valid); end
        tests++; if (y !== 8'h00)    begin fails++; $display("FAIL arst_y: got %h want 00", y); end
        @(negedge clk);
        n_reset = 1'b1;
        #1;
        tests++; if (gnt_a !== 1'b0) begin fails++; $display("FAIL arst_release_gnt_a: got %b want 0", gnt_a); end
        step();
        tests++; if (gnt_a !== 1'b1) begin fails++; $display("FAIL arst_first_grant: got %b want 1", gnt_a); end
        @(negedge clk);
        req_a = 1'b0;
    endtask

    initial begin
        data_a = '0;
        data_b = '0;
        test_reset();
        test_single_a();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
